// File: rtl/fetch_queue_mo.sv
// In-order instruction fetch queue that keeps up to MAX_INFLIGHT icache reads outstanding,
// buffers their responses for decode, and handles redirects and folds JAL targets.
`timescale 1ns/1ps
module fetch_queue_mo #(
  parameter int          QUEUE_SIZE   = 16,
  parameter int          MAX_INFLIGHT = 4,
  parameter logic [31:0] INITIAL_ADDR = 32'h0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_addr,
  output logic                            memreq_valid,
  input  logic                            memreq_ready,
  output logic [31:0]                     memreq_addr,
  input  logic                            memresp_valid,
  input  logic [31:0]                     memresp_rdata,
  input  logic                            memresp_error,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_addr,
  output logic [31:0]                     out_inst,
  output logic                            out_error,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight
);

  localparam int QAW = $clog2(QUEUE_SIZE);
  localparam int QCW = QAW + 1;
  localparam int TAW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int TCW = $clog2(MAX_INFLIGHT) + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } entry_t;

  logic [31:0]             pc_q, pc_d;
  logic [31:0]             trk_addr_q [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] trk_live_q, trk_live_d;
  logic [TAW-1:0]          trk_head_q, trk_head_d, trk_tail_q, trk_tail_d;
  logic [TCW-1:0]          inflight_q, inflight_d;
  entry_t                  fifo_mem [QUEUE_SIZE];
  logic [QAW-1:0]          fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [QCW-1:0]          fifo_count_q, fifo_count_d;

  logic [31:0]    head_addr, jal_target;
  logic [TAW-1:0] next_idx;
  logic           head_live, resp_live, is_jal, fold_needed, fold;
  logic           credit_ok, issue, pop, enq, deq;
  entry_t         fifo_head;

  function automatic logic [TAW-1:0] trk_inc(input logic [TAW-1:0] p);
    return (p == TAW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_addr  = trk_addr_q[trk_head_q];
  assign head_live  = trk_live_q[trk_head_q];
  assign next_idx   = trk_inc(trk_head_q);
  assign resp_live  = memresp_valid & head_live;
  assign is_jal     = resp_live & ~memresp_error & (memresp_rdata[6:0] == 7'b1101111);
  assign jal_target = head_addr + {{12{memresp_rdata[31]}}, memresp_rdata[19:12],
                                   memresp_rdata[20], memresp_rdata[30:21], 1'b0};
  // A younger live request already on the target path makes the fold a no-op.
  assign fold_needed = (inflight_q > TCW'(1)) ? (trk_addr_q[next_idx] != jal_target)
                                              : (pc_q != jal_target);
  assign fold        = is_jal & fold_needed & ~redirect_valid;

  assign credit_ok    = (inflight_q < TCW'(MAX_INFLIGHT)) &&
                        ((32'(fifo_count_q) + 32'(inflight_q)) < 32'(QUEUE_SIZE));
  assign memreq_valid = ~reset & ~redirect_valid & ~fold & credit_ok;
  assign memreq_addr  = pc_q;
  assign issue        = memreq_valid & memreq_ready;
  assign pop          = memresp_valid;
  assign enq          = resp_live & ~redirect_valid;

  assign fifo_head = fifo_mem[fifo_rd_q];
  assign out_valid = (fifo_count_q != '0);
  assign out_addr  = out_valid ? fifo_head.addr : '0;
  assign out_inst  = out_valid ? fifo_head.inst : '0;
  assign out_error = out_valid & fifo_head.err;
  assign deq       = out_valid & out_ready & ~redirect_valid;
  assign inflight  = inflight_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    pc_d         = pc_q;
    trk_live_d   = trk_live_q;
    trk_head_d   = pop   ? next_idx : trk_head_q;
    trk_tail_d   = issue ? trk_inc(trk_tail_q) : trk_tail_q;
    inflight_d   = inflight_q + TCW'(issue) - TCW'(pop);
    fifo_wr_d    = enq ? fifo_wr_q + 1'b1 : fifo_wr_q;
    fifo_rd_d    = deq ? fifo_rd_q + 1'b1 : fifo_rd_q;
    fifo_count_d = fifo_count_q + QCW'(enq) - QCW'(deq);

    if (redirect_valid) begin
      pc_d         = redirect_addr;
      trk_live_d   = '0;
      fifo_rd_d    = fifo_wr_q;
      fifo_count_d = '0;
    end else if (fold) begin
      pc_d       = jal_target;
      trk_live_d = '0;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
    if (issue) trk_live_d[trk_tail_q] = 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= INITIAL_ADDR;
      trk_live_q   <= '0;
      trk_head_q   <= '0;
      trk_tail_q   <= '0;
      inflight_q   <= '0;
      fifo_rd_q    <= '0;
      fifo_wr_q    <= '0;
      fifo_count_q <= '0;
    end else begin
      pc_q         <= pc_d;
      trk_live_q   <= trk_live_d;
      trk_head_q   <= trk_head_d;
      trk_tail_q   <= trk_tail_d;
      inflight_q   <= inflight_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // NOTE: storage arrays are not reset; occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    if (issue) trk_addr_q[trk_tail_q] <= pc_q;
    if (enq)   fifo_mem[fifo_wr_q]    <= {head_addr, memresp_rdata, memresp_error};
  end

  // A response with nothing outstanding breaks the cache protocol.
  assert property (@(posedge clk) disable iff (reset) !(memresp_valid && inflight_q == '0));

endmodule

// File: doc/fetch_queue_mo.md
# fetch_queue_mo

Multi-outstanding instruction fetch queue: issues in-order instruction reads to the instruction cache with up to MAX_INFLIGHT requests in flight, buffers responses in a QUEUE_SIZE-entry FIFO, and presents them in order to decode. It sits between the icache port and the decode stage. It handles external redirects (branch mispredict / trap) by flushing the FIFO and squashing in-flight responses, and folds JAL targets internally.

## Interface
Parameters:
- QUEUE_SIZE, 16, FIFO depth; power of two, ≥2
- MAX_INFLIGHT, 4, max outstanding memory requests; power of two, ≥1
- INITIAL_ADDR, 32'h0, fetch PC after reset

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  redirect request (mispredict/trap)
- redirect_addr  in  32  new fetch PC
- memreq_valid  out  1  request valid
- memreq_ready  in  1  cache accepts request
- memreq_addr  out  32  request address
- memresp_valid  in  1  in-order response valid (always accepted)
- memresp_rdata  in  32  instruction word
- memresp_error  in  1  access fault
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_addr  out  32  head PC
- out_inst  out  32  head instruction
- out_error  out  1  head fault flag
- inflight  out  $clog2(MAX_INFLIGHT)+1  requests issued and not yet responded (live + stale)

## Operation
- State: fetch pc; address tracker (MAX_INFLIGHT entries: addr, live bit); output FIFO {addr, inst, error}, count.
- Issue: memreq_valid = !reset & !redirect_valid & inflight < MAX_INFLIGHT & (fifo_count + inflight) < QUEUE_SIZE. memreq_addr = pc. On valid&ready: push {pc, live=1} into tracker, pc <= pc + 4.
- Response: pops tracker head. If head live: enqueue {head.addr, rdata, error}; else discard.
- External redirect (redirect_valid=1): FIFO emptied, all tracker entries marked stale, pc <= redirect_addr, no issue this cycle; response arriving this cycle discarded.
- JAL folding: live, error-free response with rdata[6:0]=7'b1101111, target = head.addr + sext({rdata[31],rdata[19:12],rdata[20],rdata[30:21],1'b0}). JAL itself is enqueued. If next tracker entry (live) exists with addr ≠ target, or tracker otherwise empty and pc ≠ target: mark remaining entries stale, pc <= target, suppress issue this cycle. External redirect same cycle overrides.
- PC arithmetic mod 2^32; no alignment check (cache reports faults).
- FIFO pointers wrap modulo QUEUE_SIZE; tracker modulo MAX_INFLIGHT.
- memresp_valid with inflight==0 is a protocol violation (assertion in simulation).

## Timing
- Reset values: pc=INITIAL_ADDR, FIFO empty, tracker empty; outputs memreq_valid=0, out_valid=0, out_addr/out_inst=0, out_error=0, inflight=0. Reset asserted mid-operation discards everything immediately; outputstanding cache responses after reset are the system's responsibility.
- First memreq_valid in first cycle after reset deasserts.
- Response accepted in cycle N -> out_valid earliest in N+1 (registered FIFO, no bypass).
- Output holds stable while out_valid & !out_ready.
- Full: enqueue and dequeue same cycle on full FIFO legal; credit check prevents overflow.
- Redirect in cycle N: out_valid=0 in N+1; first new request in N+1 at redirect_addr; out handshake in N ignored.
- Issue and response in same cycle: inflight unchanged.
- Sustained throughput: 1 instr/cycle with single-cycle-latency cache and out_ready=1.

## Test plan
- Reset release, cache ready, 1-cycle latency, out_ready=1: requests 0x0,0x4,0x8… one per cycle; outputs same order, first out_valid cycle 2.
- out_ready=0, QUEUE_SIZE=16, MAX_INFLIGHT=4: issue stops with fifo_count+inflight=16; no entry lost; releasing out_ready resumes at next PC.
- 3-cycle latency, 4 requests in flight, redirect to 0x100: the 4 stale responses dropped, inflight drains to new requests, first output addr 0x100.
- Response at 0x10 = JAL +0x40 while 0x14,0x18 in flight: outputs 0x10 then 0x50; 0x14/0x18 never output.
- Redirect coinciding with response and out handshake: next cycle out_valid=0, response discarded, memreq_addr=redirect_addr.
- memresp_error=1 at 0x20: entry output with out_error=1, no JAL folding, fetch continues 0x24.
